// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: MSB-first parallel-to-serial feeder with a one-word hold buffer.
// Define SERIAL_BIT_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module serial_bit_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x_out,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [FRAME-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             accept;

  function automatic logic [FRAME-1:0] frame_of(input logic [WIDTH-1:0] d);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Gated by reset so upstream never sees ready while the block is held in reset.
  assign in_ready = aresetn & ~hold_full;
  assign accept   = in_valid & in_ready;
  assign x_out    = shreg[FRAME-1];

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= frame_of(in_data);
            cnt     <= CNT_LOAD;
            state   <= SHIFT;
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            if (hold_full) begin
              shreg     <= frame_of(hold);
              cnt       <= CNT_LOAD;
              hold_full <= 1'b0;
            end else if (accept) begin
              shreg <= frame_of(in_data);
              cnt   <= CNT_LOAD;
            end else begin
              // Clearing the shifter forces x_out low while idle.
              state   <= IDLE;
              shreg   <= '0;
              x_valid <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            shreg     <= {shreg[FRAME-2:0], 1'b0};
            cnt       <= cnt - CNT_ONE;
            word_done <= (cnt == CNT_ONE);
            if (accept) begin
              hold      <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed, table-driven bench for serial_bit_feeder (WIDTH=8), parity-aware.
module tb_serial_bit_feeder;
  localparam int WIDTH = 8;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
  localparam logic [63:0] B2B_EXP = 64'b111100000_000011110_0;
`else
  localparam int FRAME = WIDTH;
  localparam logic [63:0] B2B_EXP = 64'b11110000_00001111_0;
`endif

  logic             clk = 1'b0;
  logic             aresetn = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready, x_out, x_valid, word_done, busy;

  serial_bit_feeder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .aresetn(aresetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out), .x_valid(x_valid),
    .word_done(word_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [7:0] bits;
    logic       par;
    int         z;
  } vec_t;

  vec_t        tbl[6];
  int          errors = 0;
  int          checks = 0;
  logic [63:0] cap_x, cap_v, cap_wd, cap_b, cap_rdy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic collect(input int n);
    cap_x = '0; cap_v = '0; cap_wd = '0; cap_b = '0; cap_rdy = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_x   = {cap_x[62:0], x_out};
      cap_v   = {cap_v[62:0], x_valid};
      cap_wd  = {cap_wd[62:0], word_done};
      cap_b   = {cap_b[62:0], busy};
      cap_rdy = {cap_rdy[62:0], in_ready};
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL wait_ready: in_ready got 0 expected 1 after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [7:0] d);
    wait_ready();
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [63:0] mkframe(input logic [7:0] b, input logic p);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    return {55'b0, b, p};
`else
    return {56'b0, b} | 64'(p & 1'b0);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] vmask, d;
    int          z;

    tbl[0] = '{8'hA5, 8'b10100101, 1'b0, 2};
    tbl[1] = '{8'h07, 8'b00000111, 1'b1, 0};
    tbl[2] = '{8'h55, 8'b01010101, 1'b0, 3};
    tbl[3] = '{8'h6B, 8'b01101011, 1'b1, 2};
    tbl[4] = '{8'h81, 8'b10000001, 1'b0, 0};
    tbl[5] = '{8'h3C, 8'b00111100, 1'b0, 0};
    vmask  = ((64'd1 << FRAME) - 64'd1) << 1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_outputs", {59'b0, x_out, x_valid, word_done, busy, in_ready}, 64'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {63'b0, in_ready}, 64'd1);

    // Single words from idle
    for (int t = 0; t < 6; t++) begin
      send(tbl[t].data);
      collect(FRAME + 1);
      chk($sformatf("bits_%02h", tbl[t].data), cap_x, mkframe(tbl[t].bits, tbl[t].par) << 1);
      chk($sformatf("valid_%02h", tbl[t].data), cap_v, vmask);
      chk($sformatf("word_done_%02h", tbl[t].data), cap_wd, 64'd2);
      chk($sformatf("busy_%02h", tbl[t].data), cap_b, vmask);
      d = (cap_x >> (FRAME - WIDTH + 1)) & 64'hFF;
      z = 0;
      for (int j = 0; j < WIDTH - 2; j++)
        if (((d >> j) & 64'd7) == 64'd5) z++;
      chk($sformatf("z_count_%02h", tbl[t].data), 64'(z), 64'(tbl[t].z));
    end

    // Back-to-back: F0 then 0F one cycle later
    wait_ready();
    in_data  = 8'hF0;
    in_valid = 1'b1;
    @(posedge clk);
    fork
      collect(2 * FRAME + 1);
      begin
        #1 in_data = 8'h0F;
        @(posedge clk);
        #1 in_valid = 1'b0;
      end
    join
    chk("b2b_bits", cap_x, B2B_EXP);
    chk("b2b_valid", cap_v, ((64'd1 << (2 * FRAME)) - 64'd1) << 1);
    chk("b2b_word_done", cap_wd, (64'd1 << (FRAME + 1)) | 64'd2);
    chk("b2b_ready_low_cycles",
        64'($countones(~cap_rdy & ((64'd1 << (2 * FRAME + 1)) - 64'd1))), 64'(FRAME - 1));

    // Backpressure: junk presented while in_ready is low must never appear
    wait_ready();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    fork
      collect(2 * FRAME + 1);
      begin
        #1 in_data = 8'h6B;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
          #1;
          if (in_ready) begin
            in_valid = 1'b0;
            break;
          end
          in_data = (k % 2 == 0) ? 8'hFF : 8'hAA;
          @(posedge clk);
        end
        in_valid = 1'b0;
      end
    join
    chk("bp_bits", cap_x, (mkframe(8'b00111100, 1'b0) << (FRAME + 1)) | (mkframe(8'b01101011, 1'b1) << 1));
    collect(4);
    chk("bp_no_junk", cap_v, 64'd0);

    // Reset mid-frame with a word waiting in hold
    wait_ready();
    in_data  = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h55;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_hold_full", {62'b0, in_ready, x_valid}, 64'd1);
    #2 aresetn = 1'b0;
    #1 chk("mid_reset_outputs", {59'b0, x_out, x_valid, word_done, busy, in_ready}, 64'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    send(8'h81);
    collect(FRAME + 1);
    chk("post_reset_bits", cap_x, mkframe(8'b10000001, 1'b0) << 1);
    collect(6);
    chk("post_reset_idle", cap_v | cap_x | cap_b, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
